// File: rtl/sccb_slave_if.sv
// SCCB pad split plus local register-port bundle shared by the responder
// and whatever drives it (SCCB master model or register file).
interface sccb_slave_if;
  logic       SIO_C;
  logic       SIO_DI;
  logic       SIO_DO;
  logic       SIO_DE;
  logic [7:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       reg_we;
  logic       reg_re;
  logic [7:0] reg_rdata;
  logic       busy;

  modport slave (
    input  SIO_C,
    input  SIO_DI,
    input  reg_rdata,
    output SIO_DO,
    output SIO_DE,
    output reg_addr,
    output reg_wdata,
    output reg_we,
    output reg_re,
    output busy
  );

  modport master (
    output SIO_C,
    output SIO_DI,
    output reg_rdata,
    input  SIO_DO,
    input  SIO_DE,
    input  reg_addr,
    input  reg_wdata,
    input  reg_we,
    input  reg_re,
    input  busy
  );
endinterface

// File: rtl/sccb_slave.sv
// SCCB camera-side responder: oversamples SIO_C/SIO_D on PCLK, decodes 3-phase
// writes and 2-phase reads for DEV_ID, and drives a single-cycle register port.
//
// state      | meaning
// IDLE       | bus free, waiting for START
// ID         | shifting in device ID byte
// ID_ACK     | acknowledging matching ID
// SUB        | shifting in sub-address
// SUB_ACK    | acknowledging sub-address
// WDATA      | shifting in write data
// WDATA_ACK  | acknowledging write data
// RDATA      | driving read data MSB first
// RD_NA      | master's NA bit after read data
// WAIT_STOP  | ignoring bus until STOP or repeated START
module sccb_slave (
  input logic        PCLK,
  input logic        PRESET,
  sccb_slave_if.slave bus
);

  localparam logic [6:0] DEV_ID = 7'h30;

  localparam logic [3:0] IDLE      = 4'd0;
  localparam logic [3:0] ID        = 4'd1;
  localparam logic [3:0] ID_ACK    = 4'd2;
  localparam logic [3:0] SUB       = 4'd3;
  localparam logic [3:0] SUB_ACK   = 4'd4;
  localparam logic [3:0] WDATA     = 4'd5;
  localparam logic [3:0] WDATA_ACK = 4'd6;
  localparam logic [3:0] RDATA     = 4'd7;
  localparam logic [3:0] RD_NA     = 4'd8;
  localparam logic [3:0] WAIT_STOP = 4'd9;

  logic scl_s1_q, scl_s2_q, scl_s3_q;
  logic sda_s1_q, sda_s2_q, sda_s3_q;
  logic scl_rise_q, scl_fall_q, start_q, stop_q, sda_bit_q;
  logic scl_rise_d, scl_fall_d, start_d, stop_d;

  logic [3:0] state_q, state_d;
  logic [3:0] bcnt_q, bcnt_d;
  logic [7:0] sh_q, sh_d;
  logic       rw_q, rw_d;
  logic       busy_q, busy_d;
  logic       de_q, de_d;
  logic       do_q, do_d;
  logic [7:0] addr_q, addr_d;
  logic [7:0] wdata_q, wdata_d;
  logic       we_q, we_d;
  logic       re_q, re_d;
  logic       cap_q, cap_d;
  logic [7:0] rx_byte;

  // START/STOP only when SCL is stable high; any SCL edge in the same sample wins
  assign scl_rise_d = scl_s2_q & ~scl_s3_q;
  assign scl_fall_d = ~scl_s2_q & scl_s3_q;
  assign start_d    = scl_s2_q & scl_s3_q & ~sda_s2_q & sda_s3_q;
  assign stop_d     = scl_s2_q & scl_s3_q & sda_s2_q & ~sda_s3_q;

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      scl_s1_q   <= 1'b1;
      scl_s2_q   <= 1'b1;
      scl_s3_q   <= 1'b1;
      sda_s1_q   <= 1'b1;
      sda_s2_q   <= 1'b1;
      sda_s3_q   <= 1'b1;
      scl_rise_q <= 1'b0;
      scl_fall_q <= 1'b0;
      start_q    <= 1'b0;
      stop_q     <= 1'b0;
      sda_bit_q  <= 1'b1;
    end else begin
      scl_s1_q   <= bus.SIO_C;
      scl_s2_q   <= scl_s1_q;
      scl_s3_q   <= scl_s2_q;
      sda_s1_q   <= bus.SIO_DI;
      sda_s2_q   <= sda_s1_q;
      sda_s3_q   <= sda_s2_q;
      scl_rise_q <= scl_rise_d;
      scl_fall_q <= scl_fall_d;
      start_q    <= start_d;
      stop_q     <= stop_d;
      sda_bit_q  <= sda_s2_q;
    end
  end

  assign rx_byte = {sh_q[6:0], sda_bit_q};

  always_comb begin
    state_d = state_q;
    bcnt_d  = bcnt_q;
    sh_d    = sh_q;
    rw_d    = rw_q;
    busy_d  = busy_q;
    de_d    = de_q;
    do_d    = do_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = 1'b0;
    re_d    = 1'b0;
    cap_d   = re_q;

    // register file answers the cycle after the read strobe
    if (cap_q) sh_d = bus.reg_rdata;

    if (stop_q) begin
      state_d = IDLE;
      bcnt_d  = 4'd0;
      busy_d  = 1'b0;
      de_d    = 1'b0;
      do_d    = 1'b0;
    end else if (start_q) begin
      state_d = ID;
      bcnt_d  = 4'd0;
      busy_d  = 1'b0;
      de_d    = 1'b0;
      do_d    = 1'b0;
    end else if (scl_rise_q) begin
      case (state_q)
        ID, SUB, WDATA: begin
          sh_d   = rx_byte;
          bcnt_d = bcnt_q + 4'd1;
          if (bcnt_q == 4'd7) begin
            case (state_q)
              ID: begin
                if (rx_byte[7:1] == DEV_ID) begin
                  busy_d  = 1'b1;
                  rw_d    = rx_byte[0];
                  state_d = ID_ACK;
                end else begin
                  state_d = WAIT_STOP;
                end
              end
              SUB: begin
                addr_d  = rx_byte;
                state_d = SUB_ACK;
              end
              default: begin
                wdata_d = rx_byte;
                we_d    = 1'b1;
                state_d = WDATA_ACK;
              end
            endcase
          end
        end
        ID_ACK: if (rw_q) re_d = 1'b1;
        RD_NA:  state_d = WAIT_STOP;
        default: ;
      endcase
    end else if (scl_fall_q) begin
      case (state_q)
        ID_ACK, SUB_ACK, WDATA_ACK: begin
          if (!de_q) begin
            de_d = 1'b1;
            do_d = 1'b0;
          end else begin
            de_d   = 1'b0;
            do_d   = 1'b0;
            bcnt_d = 4'd0;
            case (state_q)
              ID_ACK: begin
                if (rw_q) begin
                  // keep the pad and put the first read bit straight out
                  state_d = RDATA;
                  de_d    = 1'b1;
                  do_d    = sh_q[7];
                  sh_d    = {sh_q[6:0], 1'b0};
                  bcnt_d  = 4'd1;
                end else begin
                  state_d = SUB;
                end
              end
              SUB_ACK: state_d = WDATA;
              default: state_d = WAIT_STOP;
            endcase
          end
        end
        RDATA: begin
          if (bcnt_q == 4'd8) begin
            de_d    = 1'b0;
            do_d    = 1'b0;
            bcnt_d  = 4'd0;
            state_d = RD_NA;
          end else begin
            de_d   = 1'b1;
            do_d   = sh_q[7];
            sh_d   = {sh_q[6:0], 1'b0};
            bcnt_d = bcnt_q + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q <= IDLE;
      bcnt_q  <= 4'd0;
      sh_q    <= 8'h00;
      rw_q    <= 1'b0;
      busy_q  <= 1'b0;
      de_q    <= 1'b0;
      do_q    <= 1'b0;
      addr_q  <= 8'h00;
      wdata_q <= 8'h00;
      we_q    <= 1'b0;
      re_q    <= 1'b0;
      cap_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      bcnt_q  <= bcnt_d;
      sh_q    <= sh_d;
      rw_q    <= rw_d;
      busy_q  <= busy_d;
      de_q    <= de_d;
      do_q    <= do_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      re_q    <= re_d;
      cap_q   <= cap_d;
    end
  end

  assign bus.SIO_DO    = do_q;
  assign bus.SIO_DE    = de_q;
  assign bus.reg_addr  = addr_q;
  assign bus.reg_wdata = wdata_q;
  assign bus.reg_we    = we_q;
  assign bus.reg_re    = re_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_sccb_slave.sv
// Directed bench for sccb_slave: bit-banged SCCB master on an open-drain
// line model, register-port monitor, hand-computed expectations.
module tb_sccb_slave;

  logic       pclk;
  logic       preset;
  logic       scl;
  logic       m_sda;
  logic [7:0] rdata_v;
  logic       sda_line;

  int total = 0;
  int bad   = 0;

  int we_cnt = 0, re_cnt = 0, de_cyc = 0, busy_cyc = 0, both_cnt = 0;
  logic [7:0] we_addr = 8'h00, we_data = 8'h00, re_addr = 8'h00;

  sccb_slave_if bus();

  assign sda_line      = m_sda & ~(bus.SIO_DE & ~bus.SIO_DO);
  assign bus.SIO_DI    = sda_line;
  assign bus.SIO_C     = scl;
  assign bus.reg_rdata = rdata_v;

  sccb_slave dut (
    .PCLK   (pclk),
    .PRESET (preset),
    .bus    (bus.slave)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  always @(negedge pclk) begin
    if (bus.reg_we) begin
      we_cnt  = we_cnt + 1;
      we_addr = bus.reg_addr;
      we_data = bus.reg_wdata;
    end
    if (bus.reg_re) begin
      re_cnt  = re_cnt + 1;
      re_addr = bus.reg_addr;
    end
    if (bus.reg_we && bus.reg_re) both_cnt = both_cnt + 1;
    if (bus.SIO_DE) de_cyc = de_cyc + 1;
    if (bus.busy) busy_cyc = busy_cyc + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total = total + 1;
    if (got !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // quarter SCL period: 5 PCLK, giving 20x oversampling
  task automatic q();
    repeat (5) @(posedge pclk);
    #1;
  endtask

  task automatic bus_start();
    m_sda = 1'b1; scl = 1'b1; q();
    m_sda = 1'b0; q();
    scl = 1'b0; q();
  endtask

  task automatic bus_rstart();
    m_sda = 1'b1; q();
    scl = 1'b1; q();
    m_sda = 1'b0; q();
    scl = 1'b0; q();
  endtask

  task automatic bus_stop();
    m_sda = 1'b0; q();
    scl = 1'b1; q();
    m_sda = 1'b1; q();
    q();
  endtask

  task automatic write_bit(input logic b);
    m_sda = b; q();
    scl = 1'b1; q(); q();
    scl = 1'b0; q();
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack_line, output logic ack_de);
    for (int i = 7; i >= 0; i--) write_bit(b[i]);
    m_sda = 1'b1; q();
    scl = 1'b1; q();
    ack_line = sda_line;
    ack_de   = bus.SIO_DE;
    q();
    scl = 1'b0; q();
  endtask

  task automatic recv_byte(input logic na, output logic [7:0] b, output logic na_de);
    for (int i = 7; i >= 0; i--) begin
      m_sda = 1'b1; q();
      scl = 1'b1; q();
      b[i] = sda_line;
      q();
      scl = 1'b0; q();
    end
    m_sda = na; q();
    scl = 1'b1; q();
    na_de = bus.SIO_DE;
    q();
    scl = 1'b0; q();
  endtask

  logic       al, ad;
  logic [7:0] rb;
  int         we0, re0, de0, busy0;

  initial begin
    preset = 1'b1; scl = 1'b1; m_sda = 1'b1; rdata_v = 8'h00;
    repeat (3) @(posedge pclk);
    #1;
    chk("rst_de",    bus.SIO_DE,    0);
    chk("rst_do",    bus.SIO_DO,    0);
    chk("rst_addr",  bus.reg_addr,  8'h00);
    chk("rst_wdata", bus.reg_wdata, 8'h00);
    chk("rst_we",    bus.reg_we,    0);
    chk("rst_re",    bus.reg_re,    0);
    chk("rst_busy",  bus.busy,      0);
    preset = 1'b0;
    q(); q();

    // 3-phase write 0x60 0xFF 0x01
    we0 = we_cnt;
    bus_start();
    send_byte(8'h60, al, ad);
    chk("w_id_ack_line", al, 0); chk("w_id_ack_de", ad, 1);
    chk("w_busy", bus.busy, 1);
    send_byte(8'hFF, al, ad);
    chk("w_sub_ack_line", al, 0); chk("w_sub_ack_de", ad, 1);
    send_byte(8'h01, al, ad);
    chk("w_dat_ack_line", al, 0); chk("w_dat_ack_de", ad, 1);
    bus_stop();
    chk("w_we_count", we_cnt - we0, 1);
    chk("w_we_addr", we_addr, 8'hFF);
    chk("w_we_data", we_data, 8'h01);
    chk("w_busy_after_stop", bus.busy, 0);
    chk("w_de_after_stop", bus.SIO_DE, 0);
    q();

    // 2-phase write then read of 0xF7 returning 0x60
    we0 = we_cnt; re0 = re_cnt;
    bus_start();
    send_byte(8'h60, al, ad);
    send_byte(8'hF7, al, ad);
    chk("r_sub_ack_line", al, 0);
    bus_stop();
    chk("r_addr_loaded", bus.reg_addr, 8'hF7);
    q();
    rdata_v = 8'h60;
    bus_start();
    send_byte(8'h61, al, ad);
    chk("r_id_ack_line", al, 0); chk("r_id_ack_de", ad, 1);
    recv_byte(1'b1, rb, ad);
    chk("r_data", rb, 8'h60);
    chk("r_na_de", ad, 0);
    bus_stop();
    chk("r_re_count", re_cnt - re0, 1);
    chk("r_re_addr", re_addr, 8'hF7);
    chk("r_we_count", we_cnt - we0, 0);
    chk("r_busy_after_stop", bus.busy, 0);
    q();

    // foreign ID: never drive, never busy
    we0 = we_cnt; de0 = de_cyc; busy0 = busy_cyc;
    bus_start();
    send_byte(8'h42, al, ad);
    chk("f_ack_line", al, 1);
    send_byte(8'h12, al, ad);
    send_byte(8'h34, al, ad);
    bus_stop();
    chk("f_de_cycles", de_cyc - de0, 0);
    chk("f_busy_cycles", busy_cyc - busy0, 0);
    chk("f_we_count", we_cnt - we0, 0);
    q();

    // STOP after 4 sub-address bits
    we0 = we_cnt;
    bus_start();
    send_byte(8'h60, al, ad);
    write_bit(1'b1); write_bit(1'b0); write_bit(1'b1); write_bit(1'b0);
    bus_stop();
    chk("p_state_idle", dut.state_q, 0);
    chk("p_addr_kept", bus.reg_addr, 8'hF7);
    chk("p_we_count", we_cnt - we0, 0);
    chk("p_de", bus.SIO_DE, 0);
    chk("p_busy", bus.busy, 0);
    q();

    // repeated START after sub-address ACK, then read
    we0 = we_cnt; re0 = re_cnt;
    rdata_v = 8'h5A;
    bus_start();
    send_byte(8'h60, al, ad);
    send_byte(8'h3C, al, ad);
    bus_rstart();
    send_byte(8'h61, al, ad);
    chk("s_id_ack_line", al, 0);
    recv_byte(1'b1, rb, ad);
    chk("s_data", rb, 8'h5A);
    bus_stop();
    chk("s_re_count", re_cnt - re0, 1);
    chk("s_re_addr", re_addr, 8'h3C);
    chk("s_we_count", we_cnt - we0, 0);
    q();

    // reset pulse while driving read data
    rdata_v = 8'hA5;
    bus_start();
    send_byte(8'h61, al, ad);
    chk("x_de_before_rst", bus.SIO_DE, 1);
    chk("x_busy_before_rst", bus.busy, 1);
    #2 preset = 1'b1;
    #1;
    chk("x_de_in_rst", bus.SIO_DE, 0);
    chk("x_busy_in_rst", bus.busy, 0);
    chk("x_addr_in_rst", bus.reg_addr, 8'h00);
    @(posedge pclk); #1;
    preset = 1'b0;
    scl = 1'b1; m_sda = 1'b1;
    q(); q();
    we0 = we_cnt;
    bus_start();
    send_byte(8'h60, al, ad);
    send_byte(8'h22, al, ad);
    send_byte(8'h33, al, ad);
    chk("x_dat_ack_line", al, 0);
    bus_stop();
    chk("x_we_count", we_cnt - we0, 1);
    chk("x_we_addr", we_addr, 8'h22);
    chk("x_we_data", we_data, 8'h33);

    chk("we_re_overlap", both_cnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
